// File: rtl/bp_me_pkg.sv
// Shared types for the CCE microcode engine: fetch-stage FSM states and
// default geometry of the microcode store.
package bp_me_pkg;

    localparam int cce_pc_width_default_lp    = 8;
    localparam int cce_instr_width_default_lp = 34;

    typedef enum logic [1:0] {
        e_inst_fetch_reset = 2'd0,
        e_inst_fetch_boot  = 2'd1,
        e_inst_fetch_prime = 2'd2,
        e_inst_fetch_run   = 2'd3
    } bp_cce_inst_fetch_state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM with a registered read port; contents are not
// reset so microcode survives a CCE reset.
module bsg_mem_1rw_sync #(
    parameter int width_p      = 34,
    parameter int els_p        = 256,
    parameter int addr_width_p = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [width_p-1:0]      data_i,
    output logic [width_p-1:0]      data_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                mem_q[addr_i] <= data_i;
            end else begin
                data_q <= mem_q[addr_i];
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch stage: owns the instruction RAM and microcode PC,
// serves config-bus RAM access while booting and one instruction per cycle in run.
module bp_cce_inst_fetch
    import bp_me_pkg::*;
#(
    parameter int cce_pc_width_p    = cce_pc_width_default_lp,
    parameter int cce_instr_width_p = cce_instr_width_default_lp
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         cce_normal_mode_i,

    input  logic                         cfg_v_i,
    input  logic                         cfg_w_i,
    input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
    input  logic [cce_instr_width_p-1:0] cfg_data_i,
    output logic                         cfg_ready_and_o,
    output logic                         cfg_resp_v_o,
    output logic [cce_instr_width_p-1:0] cfg_resp_data_o,
    input  logic                         cfg_resp_yumi_i,

    input  logic                         stall_i,
    input  logic                         redirect_v_i,
    input  logic [cce_pc_width_p-1:0]    redirect_pc_i,

    output logic                         inst_v_o,
    output logic [cce_instr_width_p-1:0] inst_o,
    output logic [cce_pc_width_p-1:0]    pc_o
);

    localparam int els_lp = 1 << cce_pc_width_p;

    bp_cce_inst_fetch_state_e state_q;
    logic [cce_pc_width_p-1:0] pc_q;
    logic                      inst_v_q;
    logic                      resp_v_q;

    logic                         cfg_accept;
    logic [cce_pc_width_p-1:0]    next_pc;
    logic                         ram_v;
    logic                         ram_w;
    logic [cce_pc_width_p-1:0]    ram_addr;
    logic [cce_instr_width_p-1:0] ram_rdata;

    // A pending read response blocks new requests so the RAM output register
    // keeps holding the response data until it is consumed.
    assign cfg_ready_and_o = (state_q == e_inst_fetch_boot) & ~resp_v_q;
    assign cfg_accept      = cfg_v_i & cfg_ready_and_o;

    // Stall outranks redirect: a redirect arriving with a stall is dropped and
    // must be re-presented by execute on the replayed instruction.
    always_comb begin
        next_pc = pc_q + 1'b1;
        if (stall_i) begin
            next_pc = pc_q;
        end else if (redirect_v_i) begin
            next_pc = redirect_pc_i;
        end
    end

    always_comb begin
        ram_v    = 1'b0;
        ram_w    = 1'b0;
        ram_addr = cfg_addr_i;
        case (state_q)
            e_inst_fetch_boot: begin
                ram_v = cfg_accept;
                ram_w = cfg_w_i;
            end
            e_inst_fetch_prime: begin
                ram_v    = 1'b1;
                ram_addr = '0;
            end
            e_inst_fetch_run: begin
                ram_v    = 1'b1;
                ram_addr = next_pc;
            end
            default: begin
                ram_v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= e_inst_fetch_reset;
            pc_q     <= '0;
            inst_v_q <= 1'b0;
            resp_v_q <= 1'b0;
        end else begin
            case (state_q)
                e_inst_fetch_reset: begin
                    state_q <= e_inst_fetch_boot;
                end
                e_inst_fetch_boot: begin
                    if (resp_v_q & cfg_resp_yumi_i) begin
                        resp_v_q <= 1'b0;
                    end else if (cfg_accept & ~cfg_w_i) begin
                        resp_v_q <= 1'b1;
                    end
                    if (cce_normal_mode_i & ~cfg_accept & ~resp_v_q) begin
                        state_q <= e_inst_fetch_prime;
                    end
                end
                e_inst_fetch_prime: begin
                    pc_q     <= '0;
                    inst_v_q <= 1'b1;
                    state_q  <= e_inst_fetch_run;
                end
                e_inst_fetch_run: begin
                    pc_q <= next_pc;
                    if (~cce_normal_mode_i) begin
                        inst_v_q <= 1'b0;
                        state_q  <= e_inst_fetch_boot;
                    end
                end
                default: begin
                    state_q <= e_inst_fetch_reset;
                end
            endcase
        end
    end

    bsg_mem_1rw_sync #(
        .width_p     (cce_instr_width_p),
        .els_p       (els_lp),
        .addr_width_p(cce_pc_width_p)
    ) inst_ram (
        .clk_i (clk_i),
        .v_i   (ram_v),
        .w_i   (ram_w),
        .addr_i(ram_addr),
        .data_i(cfg_data_i),
        .data_o(ram_rdata)
    );

    assign cfg_resp_v_o    = resp_v_q;
    assign cfg_resp_data_o = ram_rdata;
    assign inst_v_o        = inst_v_q;
    assign inst_o          = ram_rdata;
    assign pc_o            = pc_q;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Bench for the CCE microcode fetch stage: directed boot/run scenarios plus a
// randomized stall/redirect run checked against an array model of the RAM.
module tb_bp_cce_inst_fetch;

    localparam int PW = 8;
    localparam int IW = 34;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          cce_normal_mode_i;
    logic          cfg_v_i;
    logic          cfg_w_i;
    logic [PW-1:0] cfg_addr_i;
    logic [IW-1:0] cfg_data_i;
    logic          cfg_ready_and_o;
    logic          cfg_resp_v_o;
    logic [IW-1:0] cfg_resp_data_o;
    logic          cfg_resp_yumi_i;
    logic          stall_i;
    logic          redirect_v_i;
    logic [PW-1:0] redirect_pc_i;
    logic          inst_v_o;
    logic [IW-1:0] inst_o;
    logic [PW-1:0] pc_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [IW-1:0] ram_model [256];
    int            model_pc;

    bp_cce_inst_fetch #(
        .cce_pc_width_p   (PW),
        .cce_instr_width_p(IW)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .cce_normal_mode_i(cce_normal_mode_i),
        .cfg_v_i          (cfg_v_i),
        .cfg_w_i          (cfg_w_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_data_i       (cfg_data_i),
        .cfg_ready_and_o  (cfg_ready_and_o),
        .cfg_resp_v_o     (cfg_resp_v_o),
        .cfg_resp_data_o  (cfg_resp_data_o),
        .cfg_resp_yumi_i  (cfg_resp_yumi_i),
        .stall_i          (stall_i),
        .redirect_v_i     (redirect_v_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_v_o         (inst_v_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_fetch(input string name, input int exp_pc);
        tests_run++;
        $display("[TB] %s: inst_v=%0b pc=%0d inst=0x%0h (exp pc=%0d inst=0x%0h)",
                 name, inst_v_o, pc_o, inst_o, exp_pc, ram_model[exp_pc]);
        if (inst_v_o !== 1'b1 || pc_o !== PW'(exp_pc) || inst_o !== ram_model[exp_pc]) begin
            tests_failed++;
            $display("FAIL %s: got v=%0b pc=%0d inst=0x%0h, want v=1 pc=%0d inst=0x%0h",
                     name, inst_v_o, pc_o, inst_o, exp_pc, ram_model[exp_pc]);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [IW-1:0] data);
        tests_run++;
        if (cfg_ready_and_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_write_ready: addr=%0d ready=%0b, want 1", addr, cfg_ready_and_o);
        end
        cfg_v_i    = 1'b1;
        cfg_w_i    = 1'b1;
        cfg_addr_i = PW'(addr);
        cfg_data_i = data;
        step();
        cfg_v_i = 1'b0;
        cfg_w_i = 1'b0;
        ram_model[addr] = data;
    endtask

    task automatic cfg_read(input int addr, input int hold);
        int waited = 0;
        while (cfg_ready_and_o !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        tests_run++;
        if (cfg_ready_and_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_read_ready: timed out, ready=%0b", cfg_ready_and_o);
        end
        cfg_v_i    = 1'b1;
        cfg_w_i    = 1'b0;
        cfg_addr_i = PW'(addr);
        step();
        cfg_v_i = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            tests_run++;
            $display("[TB] cfg read addr=%0d cycle=%0d: resp_v=%0b data=0x%0h ready=%0b",
                     addr, i, cfg_resp_v_o, cfg_resp_data_o, cfg_ready_and_o);
            if (cfg_resp_v_o !== 1'b1 || cfg_resp_data_o !== ram_model[addr] || cfg_ready_and_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_read_resp: addr=%0d got v=%0b data=0x%0h ready=%0b, want v=1 data=0x%0h ready=0",
                         addr, cfg_resp_v_o, cfg_resp_data_o, cfg_ready_and_o, ram_model[addr]);
            end
            if (i < hold) step();
        end
        cfg_resp_yumi_i = 1'b1;
        step();
        cfg_resp_yumi_i = 1'b0;
        tests_run++;
        if (cfg_resp_v_o !== 1'b0 || cfg_ready_and_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_read_yumi: got v=%0b ready=%0b, want v=0 ready=1", cfg_resp_v_o, cfg_ready_and_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        tests_run++;
        $display("[TB] reset: inst_v=%0b pc=%0d ready=%0b resp_v=%0b", inst_v_o, pc_o, cfg_ready_and_o, cfg_resp_v_o);
        if (inst_v_o !== 1'b0 || pc_o !== '0 || cfg_ready_and_o !== 1'b0 || cfg_resp_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: v=%0b pc=%0d ready=%0b resp_v=%0b, want all 0",
                     inst_v_o, pc_o, cfg_ready_and_o, cfg_resp_v_o);
        end
        reset_i = 1'b0;
        step();
        tests_run++;
        if (cfg_ready_and_o !== 1'b1 || inst_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_to_boot: ready=%0b v=%0b, want ready=1 v=0", cfg_ready_and_o, inst_v_o);
        end
    endtask

    task automatic test_boot_load();
        for (int a = 0; a < 256; a++) begin
            logic [IW-1:0] d;
            if (a < 4) d = IW'(a + 1);
            else if (a == 255) d = IW'('hAA);
            else d = IW'({$urandom(), $urandom()});
            cfg_write(a, d);
        end
        $display("[TB] boot load: wrote 256 words");
        cfg_read(2, 3);
        for (int k = 0; k < 4; k++) begin
            cfg_read(int'($urandom_range(4, 254)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_start_sequence();
        cce_normal_mode_i = 1'b1;
        step();
        tests_run++;
        if (inst_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_latency: inst_v=%0b one cycle after mode rise, want 0", inst_v_o);
        end
        step();
        check_fetch("start pc0", 0);
        step();
        check_fetch("seq pc1", 1);
        step();
        check_fetch("seq pc2", 2);
    endtask

    task automatic test_stall();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 8'd1;
        step();
        redirect_v_i = 1'b0;
        check_fetch("redirect to 1", 1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch("stall hold", 1);
        end
        stall_i = 1'b0;
        step();
        check_fetch("after stall", 2);
        step();
        check_fetch("seq pc3", 3);
    endtask

    task automatic test_redirect();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 8'd0;
        step();
        redirect_v_i = 1'b0;
        check_fetch("redirect to 0", 0);
        stall_i       = 1'b1;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 8'd100;
        step();
        stall_i      = 1'b0;
        redirect_v_i = 1'b0;
        check_fetch("stall beats redirect", 0);
    endtask

    task automatic test_wrap();
        redirect_v_i  = 1'b1;
        redirect_pc_i = 8'd255;
        step();
        redirect_v_i = 1'b0;
        check_fetch("redirect to 255", 255);
        step();
        check_fetch("wrap to 0", 0);
    endtask

    task automatic test_random_run();
        model_pc = 0;
        for (int i = 0; i < 300; i++) begin
            logic s;
            logic r;
            int   t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            t = int'($urandom_range(0, 255));
            stall_i       = s;
            redirect_v_i  = r;
            redirect_pc_i = PW'(t);
            step();
            if (s) model_pc = model_pc;
            else if (r) model_pc = t;
            else model_pc = (model_pc + 1) % 256;
            check_fetch("random", model_pc);
        end
        stall_i      = 1'b0;
        redirect_v_i = 1'b0;
    endtask

    task automatic test_mode_drop_and_reset();
        cce_normal_mode_i = 1'b0;
        cfg_v_i           = 1'b1;
        cfg_w_i           = 1'b1;
        cfg_addr_i        = 8'd0;
        cfg_data_i        = IW'('h3FF);
        tests_run++;
        if (cfg_ready_and_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_ready: ready=%0b in run, want 0", cfg_ready_and_o);
        end
        step();
        cfg_v_i = 1'b0;
        cfg_w_i = 1'b0;
        tests_run++;
        $display("[TB] mode drop: inst_v=%0b ready=%0b", inst_v_o, cfg_ready_and_o);
        if (inst_v_o !== 1'b0 || cfg_ready_and_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_drop: v=%0b ready=%0b, want v=0 ready=1", inst_v_o, cfg_ready_and_o);
        end
        cce_normal_mode_i = 1'b1;
        step();
        step();
        check_fetch("restart pc0", 0);
        step();
        reset_i = 1'b1;
        step();
        tests_run++;
        if (inst_v_o !== 1'b0 || pc_o !== '0 || cfg_ready_and_o !== 1'b0 || cfg_resp_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: v=%0b pc=%0d ready=%0b resp_v=%0b, want all 0",
                     inst_v_o, pc_o, cfg_ready_and_o, cfg_resp_v_o);
        end
        reset_i = 1'b0;
        step();
        step();
        step();
        check_fetch("post reset pc0", 0);
    endtask

    initial begin
        reset_i           = 1'b1;
        cce_normal_mode_i = 1'b0;
        cfg_v_i           = 1'b0;
        cfg_w_i           = 1'b0;
        cfg_addr_i        = '0;
        cfg_data_i        = '0;
        cfg_resp_yumi_i   = 1'b0;
        stall_i           = 1'b0;
        redirect_v_i      = 1'b0;
        redirect_pc_i     = '0;
        test_reset();
        test_boot_load();
        test_start_sequence();
        test_stall();
        test_redirect();
        test_wrap();
        test_random_run();
        test_mode_drop_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
